// File: rtl/seq_divider_16bit.sv
// Multi-cycle restoring divider for div/divu.
// One quotient bit per cycle; sign fix-up applied in a final step.
module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic             op_signed;
    logic             dvd_neg;
    logic             dsr_neg;
    logic             zero;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    step;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fit;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // dvd doubles as the quotient register: bits shift out the top
    // into the remainder while quotient bits enter at the bottom.
    always_comb begin
        rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dsr};
        fit    = ~diff[WIDTH+1];
        mag_a  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        mag_b  = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
        q_fix  = (op_signed && (dvd_neg ^ dsr_neg)) ? -dvd : dvd;
        r_fix  = (op_signed && dvd_neg) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_signed   <= 1'b0;
            dvd_neg     <= 1'b0;
            dsr_neg     <= 1'b0;
            zero        <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            step        <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_signed <= signed_op;
                        dvd_neg   <= dividend[WIDTH-1];
                        dsr_neg   <= divisor[WIDTH-1];
                        dsr       <= mag_b;
                        rem       <= '0;
                        step      <= '0;
                        // a zero divisor keeps the raw dividend for HI
                        if (divisor == '0) begin
                            zero  <= 1'b1;
                            dvd   <= dividend;
                            state <= FIX;
                        end else begin
                            zero  <= 1'b0;
                            dvd   <= mag_a;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem  <= fit ? diff[WIDTH:0] : rem_sh;
                    dvd  <= {dvd[WIDTH-2:0], fit};
                    step <= step + 1'b1;
                    if (step == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero) begin
                        quotient  <= '1;
                        remainder <= dvd;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                    div_by_zero <= zero;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
